inst_seq_constraint: RTL and testbench



---
 rtl/inst_seq_constraint.sv | 146 ++++++++++++++
 tb/tb_inst_seq_constraint.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/inst_seq_constraint.sv
// inst_seq_constraint: stateful RISC-V instruction legality constraint for ridecore formal checking.
// Ports: clk, reset (sync, active-high); instruction/inst_valid = candidate instruction;
// legal = candidate passes decode and sequence rules (1 when nothing is presented);
// inst_class = decoded class; inst_count = accepted non-NOPs; draining = program length
// exhausted (NOPs only); nop_run = current run of accepted NOPs.
// Optional macro INST_SEQ_CONSTRAINT_ASSUME_EN emits a formal assumption on legal.
module inst_seq_constraint #(
    parameter int         NUM_REGS    = 16,
    parameter int         MAX_INSTS   = 32,
    parameter int         MAX_NOP_RUN = 3,
    parameter int         MEM_IMM_MSB = 29,
    parameter logic [5:0] CLASS_MASK  = 6'b111111,
    parameter bit         NO_B2B_CF   = 1'b1,
    parameter bit         REQUIRE_DEF = 1'b0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [31:0]                        instruction,
    input  logic                               inst_valid,
    output logic                               legal,
    output logic [2:0]                         inst_class,
    output logic [$clog2(MAX_INSTS+1)-1:0]     inst_count,
    output logic                               draining,
    output logic [$clog2(MAX_NOP_RUN+2)-1:0]   nop_run
);
    localparam int CW = $clog2(MAX_INSTS + 1);
    localparam int NW = $clog2(MAX_NOP_RUN + 2);

    typedef enum logic [2:0] {
        C_ILL, C_ALUR, C_ALUI, C_MEM, C_BR, C_JMP, C_UP, C_NOP
    } cls_t;

    cls_t        cls;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        rd_ok, rs1_ok, rs2_ok, r_ok, i_ok, imm_ok;
    logic        rd_w, rs1_r, rs2_r;
    logic        is_nop, cf, cls_en, def_ok, seq_ok, accept, last_cf;
    logic [31:0] def_regs;
    logic [7:0]  en_mask;

    assign op     = instruction[6:0];
    assign rd     = instruction[11:7];
    assign f3     = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign f7     = instruction[31:25];
    assign rd_ok  = {1'b0, rd} < 6'(NUM_REGS);
    assign rs1_ok = {1'b0, rs1} < 6'(NUM_REGS);
    assign rs2_ok = {1'b0, rs2} < 6'(NUM_REGS);
    assign r_ok   = (f7 == 7'b0000000) ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                    (f7 == 7'b0000001 && !f3[2]);
    assign i_ok   = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                    (f3 == 3'b101) ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
    assign imm_ok = (instruction >> (MEM_IMM_MSB + 1)) == 32'd0;

    always_comb begin
        cls   = C_ILL;
        rd_w  = 1'b0;
        rs1_r = 1'b0;
        rs2_r = 1'b0;
        case (op)
            7'b0110011: begin
                cls   = (r_ok && rd_ok && rs1_ok && rs2_ok) ? C_ALUR : C_ILL;
                rd_w  = 1'b1;
                rs1_r = 1'b1;
                rs2_r = 1'b1;
            end
            7'b0010011: begin
                cls   = (i_ok && rd_ok && rs1_ok) ? C_ALUI : C_ILL;
                rd_w  = 1'b1;
                rs1_r = 1'b1;
            end
            7'b0000011: begin
                cls   = (f3 == 3'b010 && rd_ok && imm_ok) ? C_MEM : C_ILL;
                rd_w  = 1'b1;
                rs1_r = 1'b1;
            end
            7'b0100011: begin
                cls   = (f3 == 3'b010 && rs2_ok && imm_ok) ? C_MEM : C_ILL;
                rs1_r = 1'b1;
                rs2_r = 1'b1;
            end
            7'b1101111: begin
                cls  = C_JMP;
                rd_w = 1'b1;
            end
            7'b1100111: begin
                cls   = (f3 == 3'b000 && rd_ok && rs1_ok) ? C_JMP : C_ILL;
                rd_w  = 1'b1;
                rs1_r = 1'b1;
            end
            7'b1100011: begin
                cls   = (f3 != 3'b010 && f3 != 3'b011) ? C_BR : C_ILL;
                rs1_r = 1'b1;
                rs2_r = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                cls  = C_UP;
                rd_w = 1'b1;
            end
            7'b1111111: cls = C_NOP;
            default:    cls = C_ILL;
        endcase
    end

    // Class-indexed enable vector: ILLEGAL never enabled, NOP always enabled.
    assign en_mask    = {1'b1, CLASS_MASK, 1'b0};
    assign cls_en     = en_mask[cls];
    assign is_nop     = cls == C_NOP;
    assign cf         = cls == C_BR || cls == C_JMP;
    assign inst_class = cls;
    assign draining   = inst_count == CW'(MAX_INSTS);
    assign def_ok     = (!rs1_r || def_regs[rs1]) && (!rs2_r || def_regs[rs2]);
    assign seq_ok     = (!draining || is_nop) &&
                        !(is_nop && !draining && MAX_NOP_RUN != 0 && nop_run >= NW'(MAX_NOP_RUN)) &&
                        !(NO_B2B_CF && last_cf && cf) &&
                        (!REQUIRE_DEF || def_ok);
    assign legal      = inst_valid ? (cls_en && seq_ok) : 1'b1;
    assign accept     = inst_valid && legal && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_count <= '0;
            nop_run    <= '0;
            last_cf    <= 1'b0;
            def_regs   <= 32'h1;
        end else if (accept) begin
            if (is_nop) begin
                nop_run <= (nop_run == NW'(MAX_NOP_RUN + 1)) ? nop_run : nop_run + 1'b1;
            end else begin
                inst_count <= draining ? inst_count : inst_count + 1'b1;
                nop_run    <= '0;
                last_cf    <= cf;
                if (rd_w && rd != 5'd0) def_regs[rd] <= 1'b1;
            end
        end
    end

`ifdef INST_SEQ_CONSTRAINT_ASSUME_EN
    always @(posedge clk) if (!reset) assume property (legal);
`else
`endif
endmodule

// File: tb/tb_inst_seq_constraint.sv
// tb_inst_seq_constraint: scoreboard bench for inst_seq_constraint over three parameterisations.
module tb_inst_seq_constraint;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ins [3];
    logic [2:0]  vld = 3'b000;
    logic [2:0]  lg, dr;
    logic [2:0]  cls_a, cls_b, cls_c, nr_a, nr_b, nr_c;
    logic [5:0]  cnt_a, cnt_c;
    logic [1:0]  cnt_b;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int         id;
        string      name;
        bit         lg;
        logic [2:0] cls;
        int         cnt;
        bit         dr;
        int         nr;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    inst_seq_constraint u_a (
        .clk(clk), .reset(reset), .instruction(ins[0]), .inst_valid(vld[0]),
        .legal(lg[0]), .inst_class(cls_a), .inst_count(cnt_a), .draining(dr[0]), .nop_run(nr_a)
    );
    inst_seq_constraint #(.MAX_INSTS(2), .CLASS_MASK(6'b111011)) u_b (
        .clk(clk), .reset(reset), .instruction(ins[1]), .inst_valid(vld[1]),
        .legal(lg[1]), .inst_class(cls_b), .inst_count(cnt_b), .draining(dr[1]), .nop_run(nr_b)
    );
    inst_seq_constraint #(.REQUIRE_DEF(1'b1)) u_c (
        .clk(clk), .reset(reset), .instruction(ins[2]), .inst_valid(vld[2]),
        .legal(lg[2]), .inst_class(cls_c), .inst_count(cnt_c), .draining(dr[2]), .nop_run(nr_c)
    );

    localparam logic [31:0] ADD_1_2_3  = 32'h003100B3;
    localparam logic [31:0] ADD_17_2_3 = 32'h003108B3;
    localparam logic [31:0] ADD_3_1_2  = 32'h002081B3;
    localparam logic [31:0] ADDI_1_5   = 32'h00500093;
    localparam logic [31:0] ADDI_1_1   = 32'h00100093;
    localparam logic [31:0] ADDI_2_2   = 32'h00200113;
    localparam logic [31:0] BEQ_8      = 32'h00000463;
    localparam logic [31:0] JAL_1_4    = 32'h004000EF;
    localparam logic [31:0] NOP        = 32'h0000007F;
    localparam logic [31:0] SW_OK      = 32'h0020A023;
    localparam logic [31:0] SW_BIG     = 32'h4020A023;

    task automatic issue(input int id, input string name, input logic [31:0] w,
                         input bit l, input logic [2:0] c, input int n, input bit d, input int r);
        exp_t e;
        @(posedge clk);
        #1;
        vld     = 3'b000;
        ins[id] = w;
        vld[id] = 1'b1;
        e = '{id, name, l, c, n, d, r};
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        vld = 3'b000;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        vld   = 3'b000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t       e;
        bit         a_lg, a_dr;
        logic [2:0] a_cls;
        int         a_cnt, a_nr;
        if (vld != 3'b000) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: output presented with no expected entry");
            end else begin
                e = q.pop_front();
                case (e.id)
                    0:       begin a_lg = lg[0]; a_cls = cls_a; a_cnt = int'(cnt_a); a_dr = dr[0]; a_nr = int'(nr_a); end
                    1:       begin a_lg = lg[1]; a_cls = cls_b; a_cnt = int'(cnt_b); a_dr = dr[1]; a_nr = int'(nr_b); end
                    default: begin a_lg = lg[2]; a_cls = cls_c; a_cnt = int'(cnt_c); a_dr = dr[2]; a_nr = int'(nr_c); end
                endcase
                if ({a_lg, a_cls, a_cnt, a_dr, a_nr} !== {e.lg, e.cls, e.cnt, e.dr, e.nr}) begin
                    errors++;
                    $display("FAIL %s: got legal=%0b class=%0d count=%0d drain=%0b nop_run=%0d, want legal=%0b class=%0d count=%0d drain=%0b nop_run=%0d",
                             e.name, a_lg, a_cls, a_cnt, a_dr, a_nr, e.lg, e.cls, e.cnt, e.dr, e.nr);
                end
            end
        end else begin
            checks++;
            if (lg !== 3'b111) begin
                errors++;
                $display("FAIL idle_legal: got %b want 111", lg);
            end
        end
    end

    initial begin
        ins[0] = '0;
        ins[1] = '0;
        ins[2] = '0;
        do_reset();
        issue(0, "a_add",       ADD_1_2_3,  1, 3'd1, 0, 0, 0);
        issue(0, "a_add_rd17",  ADD_17_2_3, 0, 3'd0, 1, 0, 0);
        issue(0, "a_nop1",      NOP,        1, 3'd7, 1, 0, 0);
        issue(0, "a_nop2",      NOP,        1, 3'd7, 1, 0, 1);
        issue(0, "a_nop3",      NOP,        1, 3'd7, 1, 0, 2);
        issue(0, "a_nop4",      NOP,        0, 3'd7, 1, 0, 3);
        issue(0, "a_addi",      ADDI_1_5,   1, 3'd2, 1, 0, 3);
        issue(0, "a_nop_clr",   NOP,        1, 3'd7, 2, 0, 0);
        issue(0, "a_beq",       BEQ_8,      1, 3'd4, 2, 0, 1);
        issue(0, "a_jal_b2b",   JAL_1_4,    0, 3'd5, 3, 0, 0);
        issue(0, "a_nop_cf",    NOP,        1, 3'd7, 3, 0, 0);
        issue(0, "a_jal_held",  JAL_1_4,    0, 3'd5, 3, 0, 1);
        issue(0, "a_addi_cf",   ADDI_1_5,   1, 3'd2, 3, 0, 1);
        issue(0, "a_jal_ok",    JAL_1_4,    1, 3'd5, 4, 0, 0);
        issue(0, "a_sw_big",    SW_BIG,     0, 3'd0, 5, 0, 0);
        issue(0, "a_sw_ok",     SW_OK,      1, 3'd3, 5, 0, 0);
        idle();
        do_reset();
        issue(0, "a_post_rst",  NOP,        1, 3'd7, 0, 0, 0);
        idle();
        do_reset();
        issue(1, "b_sw_masked", SW_OK,      0, 3'd3, 0, 0, 0);
        issue(1, "b_addi1",     ADDI_1_5,   1, 3'd2, 0, 0, 0);
        issue(1, "b_addi2",     ADDI_1_1,   1, 3'd2, 1, 0, 0);
        issue(1, "b_addi_drn",  ADDI_1_5,   0, 3'd2, 2, 1, 0);
        for (int k = 0; k < 10; k++)
            issue(1, "b_drain_nop", NOP, 1, 3'd7, 2, 1, (k < 4) ? k : 4);
        idle();
        do_reset();
        issue(2, "c_add_undef", ADD_3_1_2,  0, 3'd1, 0, 0, 0);
        issue(2, "c_addi_x1",   ADDI_1_1,   1, 3'd2, 0, 0, 0);
        issue(2, "c_addi_x2",   ADDI_2_2,   1, 3'd2, 1, 0, 0);
        issue(2, "c_add_def",   ADD_3_1_2,  1, 3'd1, 2, 0, 0);
        do_reset();
        issue(2, "c_add_rst",   ADD_3_1_2,  0, 3'd1, 0, 0, 0);
        issue(2, "c_addi_x1b",  ADDI_1_1,   1, 3'd2, 0, 0, 0);
        issue(2, "c_add_part",  ADD_3_1_2,  0, 3'd1, 1, 0, 0);
        idle();
        idle();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
